// File: rtl/axi_stream_selector_pkg.sv
// axi_stream_selector_pkg: shared types and constants for the N-way stream selector
package axi_stream_selector_pkg;
  typedef enum logic [0:0] {IDLE, LOCKED} sel_state_t;
  localparam int DROP_CNT_WIDTH = 16;
endpackage

// File: rtl/axi_stream_skid_slice.sv
// axi_stream_skid_slice: main+skid register slice with a registered upstream ready
module axi_stream_skid_slice #(
  parameter int DATA_WIDTH = 16,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic [DEST_WIDTH-1:0] s_dest_i,
  input  logic [USER_WIDTH-1:0] s_user_i,
  input  logic                  s_last_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [DEST_WIDTH-1:0] m_dest_o,
  output logic [USER_WIDTH-1:0] m_user_o,
  output logic                  m_last_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i
);
  localparam int PW = DATA_WIDTH + DEST_WIDTH + USER_WIDTH + 1;
  logic [PW-1:0] in_w, main_q, main_d, skid_q, skid_d;
  logic          main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, acc, ret;
  assign in_w      = {s_data_i, s_dest_i, s_user_i, s_last_i};
  assign s_ready_o = ~skid_vld_q;
  assign acc       = s_valid_i & ~skid_vld_q;
  assign ret       = main_vld_q & m_ready_i;
  assign {m_data_o, m_dest_o, m_user_o, m_last_o} = main_q;
  assign m_valid_o = main_vld_q;
  // Refill main from skid first (skid full implies no accept), else from input; park input in skid on stall
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (ret || !main_vld_q) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = acc;
        if (acc) main_d = in_w;
      end
    end else if (acc) begin
      skid_d     = in_w;
      skid_vld_d = 1'b1;
    end
  end
  // Slice registers, emptied and zeroed on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
endmodule

// File: rtl/axi_stream_selector_n.sv
// axi_stream_selector_n: registered 1-to-N stream demux with packet-atomic selection and drop counting
module axi_stream_selector_n
  import axi_stream_selector_pkg::*;
#(
  parameter int  DATA_WIDTH  = 16,
  parameter int  DEST_WIDTH  = 8,
  parameter int  USER_WIDTH  = 8,
  parameter int  N_OUTPUTS   = 4,
  parameter int  PACKET_MODE = 1,
  localparam int ADDR_WIDTH  = $clog2(N_OUTPUTS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [ADDR_WIDTH-1:0]           address_i,
  input  logic [DATA_WIDTH-1:0]           s_data_i,
  input  logic [DEST_WIDTH-1:0]           s_dest_i,
  input  logic [USER_WIDTH-1:0]           s_user_i,
  input  logic                            s_last_i,
  input  logic                            s_valid_i,
  output logic                            s_ready_o,
  output logic [N_OUTPUTS*DATA_WIDTH-1:0] m_data_o,
  output logic [N_OUTPUTS*DEST_WIDTH-1:0] m_dest_o,
  output logic [N_OUTPUTS*USER_WIDTH-1:0] m_user_o,
  output logic [N_OUTPUTS-1:0]            m_last_o,
  output logic [N_OUTPUTS-1:0]            m_valid_o,
  input  logic [N_OUTPUTS-1:0]            m_ready_i,
  output logic [ADDR_WIDTH-1:0]           active_sel_o,
  output logic [DROP_CNT_WIDTH-1:0]       drop_count_o
);
  localparam int NS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] N_L = N_OUTPUTS[ADDR_WIDTH:0];
  sel_state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0]     lock_q, lock_d, sel;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic [N_OUTPUTS-1:0]      slice_rdy;
  logic [NS-1:0]             rdy_all;
  logic                      acc, in_range;
  assign sel          = state_q == LOCKED ? lock_q : address_i;
  assign in_range     = {1'b0, sel} < N_L;
  assign s_ready_o    = rst_ni & rdy_all[sel];
  assign acc          = s_valid_i & s_ready_o;
  assign active_sel_o = sel;
  assign drop_count_o = drop_q;
  // Ready lookup; unused (out-of-range) codes always accept so beats can be discarded
  always_comb begin
    rdy_all = '1;
    for (int k = 0; k < N_OUTPUTS; k++) rdy_all[k] = slice_rdy[k];
  end
  // Selection FSM: lock address on first beat of a multi-beat packet, release on tlast
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (PACKET_MODE != 0 && acc) begin
      if (state_q == IDLE && !s_last_i) begin
        state_d = LOCKED;
        lock_d  = address_i;
      end else if (state_q == LOCKED && s_last_i) begin
        state_d = IDLE;
      end
    end
    drop_d = (acc && !in_range && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
  end
  // FSM, lock and saturating drop counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lock_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      drop_q  <= drop_d;
    end
  end
  for (genvar k = 0; k < N_OUTPUTS; k++) begin : g_slice
    axi_stream_skid_slice #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEST_WIDTH(DEST_WIDTH),
      .USER_WIDTH(USER_WIDTH)
    ) u_slice (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .s_data_i (s_data_i),
      .s_dest_i (s_dest_i),
      .s_user_i (s_user_i),
      .s_last_i (s_last_i),
      .s_valid_i(s_valid_i && sel == ADDR_WIDTH'(k)),
      .s_ready_o(slice_rdy[k]),
      .m_data_o (m_data_o[k*DATA_WIDTH +: DATA_WIDTH]),
      .m_dest_o (m_dest_o[k*DEST_WIDTH +: DEST_WIDTH]),
      .m_user_o (m_user_o[k*USER_WIDTH +: USER_WIDTH]),
      .m_last_o (m_last_o[k]),
      .m_valid_o(m_valid_o[k]),
      .m_ready_i(m_ready_i[k])
    );
  end
endmodule

// File: tb/tb_axi_stream_selector_n.sv
// tb_axi_stream_selector_n: directed table + sequence checks for the N-way stream selector
module tb_axi_stream_selector_n;
  logic        clk = 0, rst_n = 0;
  logic [1:0]  addr = 0;
  logic [15:0] s_data = 0;
  logic [7:0]  s_dest = 8'hA5, s_user = 8'h3C;
  logic        s_last = 0, s_valid = 0;
  logic        a_s_ready, b_s_ready;
  logic [63:0] ma_data;
  logic [31:0] ma_dest, ma_user;
  logic [3:0]  ma_last, ma_valid, ma_ready = '1;
  logic [1:0]  a_sel, b_sel;
  logic [15:0] a_drop, b_drop;
  logic [47:0] mb_data;
  logic [23:0] mb_dest, mb_user;
  logic [2:0]  mb_last, mb_valid, mb_ready = '1;
  int checks = 0, errors = 0;
  int idx, got, n;
  logic acc, ret;
  logic [15:0] rd;

  typedef struct packed {
    logic v; logic [1:0] a; logic [15:0] d; logic l;
    logic rdy; logic [1:0] sel; logic [3:0] mv; logic [1:0] port;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  axi_stream_selector_n #(.N_OUTPUTS(4), .PACKET_MODE(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .address_i(addr),
    .s_data_i(s_data), .s_dest_i(s_dest), .s_user_i(s_user), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(a_s_ready),
    .m_data_o(ma_data), .m_dest_o(ma_dest), .m_user_o(ma_user), .m_last_o(ma_last),
    .m_valid_o(ma_valid), .m_ready_i(ma_ready),
    .active_sel_o(a_sel), .drop_count_o(a_drop));

  axi_stream_selector_n #(.N_OUTPUTS(3), .PACKET_MODE(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .address_i(addr),
    .s_data_i(s_data), .s_dest_i(s_dest), .s_user_i(s_user), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(b_s_ready),
    .m_data_o(mb_data), .m_dest_o(mb_dest), .m_user_o(mb_user), .m_last_o(mb_last),
    .m_valid_o(mb_valid), .m_ready_i(mb_ready),
    .active_sel_o(b_sel), .drop_count_o(b_drop));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 2'd2, 16'(i + 1), i == 7, 1'b1, 2'd2, 4'b0100, 2'd2};
    tbl[8]  = '{1'b0, 2'd1, 16'h0,  1'b0, 1'b1, 2'd1, 4'b0000, 2'd0};
    tbl[9]  = '{1'b1, 2'd1, 16'h11, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd1};
    tbl[10] = '{1'b1, 2'd1, 16'h12, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd1};
    tbl[11] = '{1'b1, 2'd3, 16'h13, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd1};
    tbl[12] = '{1'b1, 2'd3, 16'h14, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd1};
    tbl[13] = '{1'b1, 2'd3, 16'h21, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3};
    tbl[14] = '{1'b1, 2'd0, 16'h22, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd3};
    tbl[15] = '{1'b0, 2'd0, 16'h0,  1'b0, 1'b1, 2'd0, 4'b0000, 2'd0};

    repeat (2) @(negedge clk);
    #1;
    check("rst_valid_a", 32'(ma_valid), 32'h0);
    check("rst_ready_a", 32'(a_s_ready), 32'h0);
    check("rst_drop_a", 32'(a_drop), 32'h0);
    check("rst_sel_a", 32'(a_sel), 32'h0);
    check("rst_valid_b", 32'(mb_valid), 32'h0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_valid = tbl[i].v; addr = tbl[i].a; s_data = tbl[i].d; s_last = tbl[i].l;
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(a_s_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d_sel", i), 32'(a_sel), 32'(tbl[i].sel));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_valid", i), 32'(ma_valid), 32'(tbl[i].mv));
      if (tbl[i].mv != 0)
        check($sformatf("tbl%0d_data", i), 32'(ma_data[tbl[i].port*16 +: 16]), 32'(tbl[i].d));
    end

    idx = 0; got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge clk);
      ma_ready[0] = c >= 5;
      addr = 0; s_valid = idx < 4; s_data = 16'(16'h31 + idx); s_last = idx == 3;
      #1;
      if (c < 5) check($sformatf("bp_ready%0d", c), 32'(a_s_ready), 32'(c < 2));
      acc = s_valid & a_s_ready;
      ret = ma_valid[0] & ma_ready[0];
      rd  = ma_data[15:0];
      @(posedge clk);
      if (acc) idx++;
      if (ret) begin
        check($sformatf("bp_order%0d", got), 32'(rd), 32'(16'h31 + got));
        got++;
      end
    end
    check("bp_count", 32'(got), 32'd4);

    @(negedge clk);
    s_valid = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1; addr = 3; n = 0;
    for (int c = 0; c < 30 && n < 10; c++) begin
      @(negedge clk);
      s_valid = 1; s_data = 16'(70 + n); s_last = n == 9;
      #1;
      acc = b_s_ready;
      @(posedge clk);
      if (acc) n++;
      #1;
      check("drop_no_valid", 32'(mb_valid), 32'h0);
    end
    @(negedge clk);
    s_valid = 0;
    check("drop_accepted", 32'(n), 32'd10);
    check("drop_count", 32'(b_drop), 32'd10);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      addr = 2'(i % 2); s_valid = 1; s_data = 16'(16'h41 + i); s_last = 1;
      #1;
      check($sformatf("tog%0d_ready", i), 32'(b_s_ready), 32'h1);
      check($sformatf("tog%0d_sel", i), 32'(b_sel), 32'(i % 2));
      @(posedge clk);
      #1;
      check($sformatf("tog%0d_valid", i), 32'(mb_valid), 32'(1 << (i % 2)));
      check($sformatf("tog%0d_data", i), 32'(mb_data[(i % 2)*16 +: 16]), 32'(16'h41 + i));
    end

    @(negedge clk);
    s_valid = 0; ma_ready = '0; addr = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_valid = 1; s_data = 16'(16'h51 + i); s_last = 0;
      #1;
      check($sformatf("fill%0d_ready", i), 32'(a_s_ready), 32'(i < 2));
    end
    @(negedge clk);
    addr = 1; rst_n = 0; s_data = 16'h61; s_last = 1;
    #1;
    check("mid_rst_valid", 32'(ma_valid), 32'h0);
    check("mid_rst_ready", 32'(a_s_ready), 32'h0);
    check("mid_rst_drop_b", 32'(b_drop), 32'h0);
    check("mid_rst_sel", 32'(a_sel), 32'h1);
    @(negedge clk);
    rst_n = 1; ma_ready = '1;
    #1;
    check("post_rst_ready", 32'(a_s_ready), 32'h1);
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(ma_valid), 32'b0010);
    check("post_rst_data", 32'(ma_data[31:16]), 32'h61);
    check("post_rst_last", 32'(ma_last[1]), 32'h1);
    check("post_rst_dest", 32'(ma_dest[15:8]), 32'hA5);
    check("post_rst_user", 32'(ma_user[15:8]), 32'h3C);
    @(negedge clk);
    s_valid = 0;
    @(posedge clk);
    #1;
    check("post_rst_drain", 32'(ma_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
